// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: UART register map,
// scheduler state encoding and a round-robin pointer helper.
package uart_tx_sched_pkg;

  // UART register offsets relative to UART_BASE
  localparam logic [31:0] REG_CTRL   = 32'h0000_0000;
  localparam logic [31:0] REG_STATUS = 32'h0000_0004;
  localparam logic [31:0] REG_BAUD   = 32'h0000_0008;
  localparam logic [31:0] REG_TXDATA = 32'h0000_000C;

  // STATUS bit that reads 1 while the transmitter is still shifting a byte
  localparam int STATUS_BUSY_BIT = 0;

  // CTRL value programmed at init: transmitter enable
  localparam logic [31:0] CTRL_TX_EN = 32'h0000_0001;

  typedef enum logic [2:0] {
    S_INIT_BAUD,
    S_INIT_CTRL,
    S_IDLE,
    S_POLL,
    S_CHK,
    S_WRITE,
    S_GAP
  } state_e;

  // Index following idx in a ring of num_req requesters
  function automatic logic [2:0] rr_next(input logic [2:0] idx, input int num_req);
    if (int'(idx) >= num_req - 1) return 3'd0;
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Grants the first asserted
// request at or after ptr, wrapping modulo NUM_REQ.
// Ports:
//   req        in  NUM_REQ  request vector
//   ptr        in  3        highest-priority index (must be < NUM_REQ)
//   grant_oh   out NUM_REQ  one-hot grant (all zero when nothing requests)
//   grant_idx  out 3        index of the granted request
//   grant_any  out 1        at least one request present
module rr_arbiter
  import uart_tx_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [2:0]         grant_idx,
  output logic               grant_any
);

  // Each request's distance from ptr around the ring; the closest one wins.
  always_comb begin : pick
    int best_d;
    int d;
    best_d    = NUM_REQ;
    d         = 0;
    grant_idx = '0;
    grant_any = 1'b0;
    grant_oh  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      d = j - int'(ptr);
      if (d < 0) d = d + NUM_REQ;
      if (req[j] && (d < best_d)) begin
        best_d    = d;
        grant_idx = 3'(j);
        grant_any = 1'b1;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      grant_oh[j] = grant_any && (grant_idx == 3'(j));
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one memory-mapped UART
// transmitter between NUM_REQ byte-stream requesters. After reset it writes
// BAUD then CTRL, then for every granted byte polls STATUS until the busy bit
// clears and writes the byte to TXDATA. Sole master of the UART register port.
//
// Optional feature: define UART_TX_SCHED_PKT_LOCK_EN to keep the round-robin
// pointer on a requester until it sends a byte with req_last=1, so packets are
// never interleaved. Without it req_last is ignored (per-byte round-robin).
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   req_valid    per-requester byte available
//   req_data     byte i on req_data[8i+7:8i]; held stable until req_ready[i]
//   req_last     per-requester end-of-packet flag (packet lock build only)
//   req_ready    one-cycle pulse when byte i is written to TXDATA
//   grant_id     current/last granted requester
//   init_done    BAUD and CTRL programmed
//   uart_we/waddr/wdata   register write port
//   uart_re/raddr         register read port
//   uart_rdata            read data, valid the cycle after uart_re
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int          NUM_REQ   = 4,
  parameter logic [31:0] BAUD_DIV  = 32'h0000_01B8,
  parameter logic [31:0] UART_BASE = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [2:0]             grant_id,
  output logic                   init_done,
  output logic                   uart_we,
  output logic [31:0]            uart_waddr,
  output logic [31:0]            uart_wdata,
  output logic                   uart_re,
  output logic [31:0]            uart_raddr,
  input  logic [31:0]            uart_rdata
);

  state_e       state_q, state_d;
  logic         run_q, run_d;
  logic [2:0]   rr_q, rr_d;
  logic [2:0]   grant_q, grant_d;
  logic         init_done_q, init_done_d;
  logic [7:0]   byte_q, byte_d;

  logic [NUM_REQ-1:0] arb_oh;
  logic [2:0]         arb_idx;
  logic               arb_any;
  logic               take;
  logic               blocked;
  logic               hold_ptr;
  logic               unused_rdata;

  // Only the busy bit of STATUS matters
  assign unused_rdata = ^(uart_rdata & ~(32'h1 << STATUS_BUSY_BIT));

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_q),
    .grant_oh  (arb_oh),
    .grant_idx (arb_idx),
    .grant_any (arb_any)
  );

`ifdef UART_TX_SCHED_PKT_LOCK_EN
  logic lock_q, lock_d;
  logic last_q, last_d;

  // While locked the pointer sits on the packet owner; if the owner has no
  // byte the arbiter would pick someone else, which must not be granted.
  assign blocked  = lock_q && (arb_idx != rr_q);
  assign hold_ptr = ~last_q;

  always_comb begin
    last_d = last_q;
    lock_d = lock_q;
    if (state_q == S_IDLE && take) last_d = |(req_last & arb_oh);
    if (state_q == S_WRITE) lock_d = ~last_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q <= 1'b0;
      last_q <= 1'b1;
    end else begin
      lock_q <= lock_d;
      last_q <= last_d;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign blocked     = 1'b0;
  assign hold_ptr    = 1'b0;
`endif

  assign take = arb_any & ~blocked;

  // Byte captured at grant; requester holds it stable until req_ready anyway.
  always_comb begin
    byte_d = byte_q;
    if (state_q == S_IDLE && take) begin
      byte_d = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
        byte_d = byte_d | (req_data[8*j +: 8] & {8{arb_oh[j]}});
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    run_d       = 1'b1;
    rr_d        = rr_q;
    grant_d     = grant_q;
    init_done_d = init_done_q;
    uart_we     = 1'b0;
    uart_waddr  = '0;
    uart_wdata  = '0;
    uart_re     = 1'b0;
    uart_raddr  = '0;
    req_ready   = '0;
    case (state_q)
      // run_q holds off the BAUD write for the first cycle after reset so
      // every output reads 0 while rst is asserted.
      S_INIT_BAUD: begin
        if (run_q) begin
          uart_we    = 1'b1;
          uart_waddr = UART_BASE + REG_BAUD;
          uart_wdata = BAUD_DIV;
          state_d    = S_INIT_CTRL;
        end
      end
      S_INIT_CTRL: begin
        uart_we     = 1'b1;
        uart_waddr  = UART_BASE + REG_CTRL;
        uart_wdata  = CTRL_TX_EN;
        init_done_d = 1'b1;
        state_d     = S_IDLE;
      end
      S_IDLE: begin
        if (take) begin
          grant_d = arb_idx;
          state_d = S_POLL;
        end
      end
      S_POLL: begin
        uart_re    = 1'b1;
        uart_raddr = UART_BASE + REG_STATUS;
        state_d    = S_CHK;
      end
      S_CHK: begin
        state_d = uart_rdata[STATUS_BUSY_BIT] ? S_POLL : S_WRITE;
      end
      S_WRITE: begin
        uart_we    = 1'b1;
        uart_waddr = UART_BASE + REG_TXDATA;
        uart_wdata = {24'h0, byte_q};
        for (int j = 0; j < NUM_REQ; j++) begin
          req_ready[j] = (grant_q == 3'(j));
        end
        rr_d    = hold_ptr ? grant_q : rr_next(grant_q, NUM_REQ);
        state_d = S_GAP;
      end
      // Idle cycle so the UART's busy bit is set before the next poll
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_INIT_BAUD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT_BAUD;
      run_q       <= 1'b0;
      rr_q        <= '0;
      grant_q     <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      init_done_q <= init_done_d;
    end
  end

  always_ff @(posedge clk) begin
    byte_q <= byte_d;
  end

  assign grant_id  = grant_q;
  assign init_done = init_done_q;

endmodule
